// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: forwards, extends the immediate and registers the ALU operand bundle.
// 1-cycle capture-to-valid; holds under out_ready=0; stalls upstream on load-use (optional ALU_FWD_EN macro enables forwarding).
// Backpressure: in_ready drops when the held entry is stalled downstream or a hazard is detected.
module id_ex_operand_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_W     = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    input  logic [REG_ADDR_W-1:0] dest_addr_in,
    input  logic [DATA_W-1:0]     rs_data,
    input  logic [DATA_W-1:0]     rt_data,
    input  logic [15:0]           imm16,
    input  logic                  alu_src,
    input  logic                  imm_sext,
    input  logic [CTRL_W-1:0]     alu_control_in,
    input  logic                  reg_write_in,
    input  logic                  mem_read_in,
    input  logic                  flush,
    input  logic                  exmem_reg_write,
    input  logic [REG_ADDR_W-1:0] exmem_dest,
    input  logic [DATA_W-1:0]     exmem_result,
    input  logic                  memwb_reg_write,
    input  logic [REG_ADDR_W-1:0] memwb_dest,
    input  logic [DATA_W-1:0]     memwb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     a,
    output logic [DATA_W-1:0]     b,
    output logic [DATA_W-1:0]     store_data,
    output logic [CTRL_W-1:0]     alu_control,
    output logic [REG_ADDR_W-1:0] dest_addr,
    output logic                  reg_write,
    output logic                  mem_read,
    output logic                  load_use_stall
);

    logic                  out_valid_q, out_valid_d;
    logic [DATA_W-1:0]     a_q, a_d, b_q, b_d, sd_q, sd_d;
    logic [CTRL_W-1:0]     ctrl_q;
    logic [REG_ADDR_W-1:0] dest_q;
    logic                  rw_q, mr_q;

    logic [DATA_W-1:0]     imm_ext;
    logic [DATA_W-1:0]     fwd_rs, fwd_rt;
    logic                  raw_stall;
    logic                  base_stall;
    logic                  capture;

    assign imm_ext = imm_sext ? {{(DATA_W-16){imm16[15]}}, imm16}
                              : {{(DATA_W-16){1'b0}}, imm16};

`ifdef ALU_FWD_EN
    always_comb begin
        fwd_rs    = rs_data;
        fwd_rt    = rt_data;
        raw_stall = 1'b0;
        // EX/MEM is the younger producer, so it wins over MEM/WB.
        if (rs_addr != '0) begin
            if (exmem_reg_write && exmem_dest == rs_addr)      fwd_rs = exmem_result;
            else if (memwb_reg_write && memwb_dest == rs_addr) fwd_rs = memwb_data;
        end
        if (rt_addr != '0) begin
            if (exmem_reg_write && exmem_dest == rt_addr)      fwd_rt = exmem_result;
            else if (memwb_reg_write && memwb_dest == rt_addr) fwd_rt = memwb_data;
        end
    end
`else
    logic rs_hit, rt_hit;
    always_comb begin
        fwd_rs = rs_data;
        fwd_rt = rt_data;
        // Without forwarding, any in-flight writer of a source must drain first.
        rs_hit = (rs_addr != '0) &&
                 ((out_valid_q && rw_q && dest_q == rs_addr) ||
                  (exmem_reg_write && exmem_dest == rs_addr) ||
                  (memwb_reg_write && memwb_dest == rs_addr));
        rt_hit = (rt_addr != '0) &&
                 ((out_valid_q && rw_q && dest_q == rt_addr) ||
                  (exmem_reg_write && exmem_dest == rt_addr) ||
                  (memwb_reg_write && memwb_dest == rt_addr));
        raw_stall = in_valid && (rs_hit || rt_hit);
    end
`endif

    assign base_stall = out_valid_q && mr_q && (dest_q != '0) && in_valid &&
                        ((dest_q == rs_addr) || (dest_q == rt_addr));
    assign load_use_stall = base_stall || raw_stall;
    assign in_ready       = (!out_valid_q || out_ready) && !load_use_stall;
    assign capture        = in_valid && in_ready && !flush;

    assign a_d  = fwd_rs;
    assign b_d  = alu_src ? imm_ext : fwd_rt;
    assign sd_d = fwd_rt;

    always_comb begin
        out_valid_d = out_valid_q;
        if (flush)          out_valid_d = 1'b0;
        else if (capture)   out_valid_d = 1'b1;
        else if (out_ready) out_valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sd_q        <= '0;
            ctrl_q      <= '0;
            dest_q      <= '0;
            rw_q        <= 1'b0;
            mr_q        <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (capture) begin
                a_q    <= a_d;
                b_q    <= b_d;
                sd_q   <= sd_d;
                ctrl_q <= alu_control_in;
                dest_q <= dest_addr_in;
                rw_q   <= reg_write_in;
                mr_q   <= mem_read_in;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign a           = a_q;
    assign b           = b_q;
    assign store_data  = sd_q;
    assign alu_control = ctrl_q;
    assign dest_addr   = dest_q;
    assign reg_write   = rw_q;
    assign mem_read    = mr_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: vector table plus hazard/flush/reset sequences.
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready;
    logic [4:0]  rs_addr, rt_addr, dest_addr_in;
    logic [31:0] rs_data, rt_data;
    logic [15:0] imm16;
    logic        alu_src, imm_sext;
    logic [5:0]  alu_control_in;
    logic        reg_write_in, mem_read_in, flush;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_dest, memwb_dest;
    logic [31:0] exmem_result, memwb_data;
    logic        out_valid, out_ready;
    logic [31:0] a, b, store_data;
    logic [5:0]  alu_control;
    logic [4:0]  dest_addr;
    logic        reg_write, mem_read, load_use_stall;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .dest_addr_in(dest_addr_in),
        .rs_data(rs_data), .rt_data(rt_data), .imm16(imm16),
        .alu_src(alu_src), .imm_sext(imm_sext), .alu_control_in(alu_control_in),
        .reg_write_in(reg_write_in), .mem_read_in(mem_read_in), .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_dest(exmem_dest), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_dest(memwb_dest), .memwb_data(memwb_data),
        .out_valid(out_valid), .out_ready(out_ready), .a(a), .b(b), .store_data(store_data),
        .alu_control(alu_control), .dest_addr(dest_addr), .reg_write(reg_write),
        .mem_read(mem_read), .load_use_stall(load_use_stall)
    );

    typedef struct {
        logic [4:0]  rs, rt, dst;
        logic [31:0] rsd, rtd;
        logic [15:0] imm;
        logic        src, sext;
        logic [5:0]  ctrl;
        logic        exw;
        logic [4:0]  exd;
        logic [31:0] exr;
        logic [31:0] exp_a, exp_b, exp_sd;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            passed++;
    endtask

    task automatic idle();
        in_valid = 0; rs_addr = 0; rt_addr = 0; dest_addr_in = 0;
        rs_data = 0; rt_data = 0; imm16 = 0; alu_src = 0; imm_sext = 0;
        alu_control_in = 0; reg_write_in = 0; mem_read_in = 0; flush = 0;
        exmem_reg_write = 0; exmem_dest = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_dest = 0; memwb_data = 0; out_ready = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{rs:3, rt:4, dst:1, rsd:10, rtd:5, imm:16'h0, src:0, sext:0, ctrl:6'b100011,
                    exw:0, exd:0, exr:0, exp_a:10, exp_b:5, exp_sd:5};
        vecs[1] = '{rs:1, rt:2, dst:2, rsd:1, rtd:2, imm:16'hFFFE, src:1, sext:1, ctrl:6'b100000,
                    exw:0, exd:0, exr:0, exp_a:1, exp_b:32'hFFFFFFFE, exp_sd:2};
        vecs[2] = '{rs:1, rt:2, dst:2, rsd:1, rtd:2, imm:16'hFFFE, src:1, sext:0, ctrl:6'b100001,
                    exw:0, exd:0, exr:0, exp_a:1, exp_b:32'h0000FFFE, exp_sd:2};
        vecs[3] = '{rs:0, rt:6, dst:3, rsd:123, rtd:9, imm:16'h0, src:0, sext:0, ctrl:6'b000010,
                    exw:1, exd:0, exr:99, exp_a:123, exp_b:9, exp_sd:9};
        vecs[4] = '{rs:8, rt:9, dst:4, rsd:55, rtd:66, imm:16'h7FFF, src:1, sext:1, ctrl:6'b101010,
                    exw:0, exd:0, exr:0, exp_a:55, exp_b:32'h00007FFF, exp_sd:66};

        idle();
        reset = 1; in_valid = 1; rs_data = 32'hDEAD; rt_data = 32'hBEEF;
        tick(); tick();
        chk("rst_valid", {31'b0, out_valid}, 0);
        chk("rst_a", a, 0);
        chk("rst_b", b, 0);
        chk("rst_ctrl", {26'b0, alu_control}, 0);
        @(negedge clk);
        reset = 0; idle();
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 1);

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            idle();
            in_valid = 1; rs_addr = vecs[i].rs; rt_addr = vecs[i].rt; dest_addr_in = vecs[i].dst;
            rs_data = vecs[i].rsd; rt_data = vecs[i].rtd; imm16 = vecs[i].imm;
            alu_src = vecs[i].src; imm_sext = vecs[i].sext; alu_control_in = vecs[i].ctrl;
            exmem_reg_write = vecs[i].exw; exmem_dest = vecs[i].exd; exmem_result = vecs[i].exr;
            tick();
            chk($sformatf("v%0d_valid", i), {31'b0, out_valid}, 1);
            chk($sformatf("v%0d_a", i), a, vecs[i].exp_a);
            chk($sformatf("v%0d_b", i), b, vecs[i].exp_b);
            chk($sformatf("v%0d_sd", i), store_data, vecs[i].exp_sd);
            chk($sformatf("v%0d_ctrl", i), {26'b0, alu_control}, {26'b0, vecs[i].ctrl});
        end

        // Both producers target r7: the EX/MEM value must win.
        @(negedge clk);
        idle();
        in_valid = 1; rs_addr = 7; rs_data = 1;
        exmem_reg_write = 1; exmem_dest = 7; exmem_result = 99;
        memwb_reg_write = 1; memwb_dest = 7; memwb_data = 42;
`ifdef ALU_FWD_EN
        tick();
        chk("fwd_exmem_a", a, 99);
        @(negedge clk);
        exmem_reg_write = 0;
        tick();
        chk("fwd_memwb_a", a, 42);
`else
        #1;
        chk("raw_stall", {31'b0, load_use_stall}, 1);
        chk("raw_in_ready", {31'b0, in_ready}, 0);
        tick();
        chk("raw_bubble", {31'b0, out_valid}, 0);
        @(negedge clk);
        exmem_reg_write = 0; memwb_reg_write = 0;
        tick();
        chk("raw_release_valid", {31'b0, out_valid}, 1);
        chk("raw_release_a", a, 1);
`endif

        // Load into r5 followed by a consumer of r5.
        @(negedge clk);
        idle();
        in_valid = 1; rs_addr = 1; rt_addr = 2; dest_addr_in = 5; rs_data = 3;
        reg_write_in = 1; mem_read_in = 1;
        tick();
        chk("lu_load_valid", {31'b0, out_valid}, 1);
        chk("lu_load_mr", {31'b0, mem_read}, 1);
        @(negedge clk);
        idle();
        in_valid = 1; rs_addr = 5; rs_data = 11; dest_addr_in = 6;
        #1;
        chk("lu_stall", {31'b0, load_use_stall}, 1);
        chk("lu_in_ready", {31'b0, in_ready}, 0);
        tick();
        chk("lu_bubble", {31'b0, out_valid}, 0);
        @(negedge clk);
        memwb_reg_write = 1; memwb_dest = 5; memwb_data = 77;
`ifdef ALU_FWD_EN
        #1;
        chk("lu_stall_clear", {31'b0, load_use_stall}, 0);
        tick();
        chk("lu_cap_valid", {31'b0, out_valid}, 1);
        chk("lu_cap_a", a, 77);
`else
        #1;
        chk("lu_stall_wb", {31'b0, load_use_stall}, 1);
        tick();
        chk("lu_bubble2", {31'b0, out_valid}, 0);
        @(negedge clk);
        memwb_reg_write = 0;
        tick();
        chk("lu_cap_valid", {31'b0, out_valid}, 1);
        chk("lu_cap_a", a, 11);
`endif

        // Held entry under backpressure, then flushed together with a pending instruction.
        @(negedge clk);
        idle();
        in_valid = 1; rs_addr = 1; rs_data = 200;
        tick();
        chk("fl_cap_a", a, 200);
        @(negedge clk);
        out_ready = 0; rs_data = 300;
        #1;
        chk("hold_in_ready", {31'b0, in_ready}, 0);
        tick();
        chk("hold_valid", {31'b0, out_valid}, 1);
        chk("hold_a", a, 200);
        @(negedge clk);
        flush = 1;
        tick();
        chk("flush_valid", {31'b0, out_valid}, 0);
        @(negedge clk);
        flush = 0; in_valid = 0; out_ready = 1;
        tick();
        chk("flush_drop_valid", {31'b0, out_valid}, 0);
        chk("flush_drop_a", a, 200);

        // Reset while an entry is held.
        @(negedge clk);
        in_valid = 1; out_ready = 0; rs_data = 400;
        tick();
        chk("mid_cap_a", a, 400);
        @(negedge clk);
        reset = 1;
        tick();
        chk("mid_rst_valid", {31'b0, out_valid}, 0);
        chk("mid_rst_a", a, 0);
        @(negedge clk);
        reset = 0; idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
